// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register outstanding-write scoreboard with decode stall
//
// Tracks a 2-bit count of in-flight writes for each architectural register
// x1..x31 (x0 is hardwired to zero) and stalls decode on RAW hazards or when
// a destination counter is already full.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ID_valid                   instruction present in decode
//   ID_rs1/ID_rs2, ID_use_rs*  decode sources and whether they are read
//   ID_rd, ID_RegWrite         decode destination and write enable
//   WB_rd, WB_RegWrite         retiring write
//   KILL_rd, KILL_valid        squashed in-flight writer
//   Flush_all                  discard all outstanding writes
//   Stall                      combinational decode hold
//   Pending                    registered, bit r set when cnt[r] != 0
//   InFlight                   registered sum of all counts
//   Error                      registered sticky counter-underflow flag

module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic [4:0]  ID_rd,
  input  logic        ID_RegWrite,
  input  logic [4:0]  WB_rd,
  input  logic        WB_RegWrite,
  input  logic [4:0]  KILL_rd,
  input  logic        KILL_valid,
  input  logic        Flush_all,
  output logic        Stall,
  output logic [31:0] Pending,
  output logic [6:0]  InFlight,
  output logic        Error
);

  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic [1:0]  dec   [32];
  logic [1:0]  eff   [32];
  logic [31:0] pending_q, pending_d;
  logic [6:0]  inflight_q, inflight_d;
  logic        error_q, error_d;
  logic        src1_haz, src2_haz, dest_haz;
  logic        issue;
  logic        underflow;

  // Decrements this cycle and the bypassed count decode sees: a write that
  // retires (or is killed) this cycle no longer blocks a reader.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      dec[r] = 2'd0;
      eff[r] = 2'd0;
      if (r != 0) begin
        dec[r] = {1'b0, WB_RegWrite && (WB_rd == 5'(r))}
               + {1'b0, KILL_valid && (KILL_rd == 5'(r))};
        eff[r] = (cnt_q[r] > dec[r]) ? (cnt_q[r] - dec[r]) : 2'd0;
      end
    end
  end

  always_comb begin
    src1_haz = ID_use_rs1 && (ID_rs1 != 5'd0) && (eff[ID_rs1] != 2'd0);
    src2_haz = ID_use_rs2 && (ID_rs2 != 5'd0) && (eff[ID_rs2] != 2'd0);
    // A full counter cannot accept another outstanding write.
    dest_haz = ID_RegWrite && (ID_rd != 5'd0) && (eff[ID_rd] == 2'd3);
    Stall    = ID_valid && (src1_haz || src2_haz || dest_haz);
    issue    = ID_valid && !Stall;
  end

  // Next counts in 3 bits; a negative result clamps to 0 and flags underflow.
  // The dest hazard keeps the result at or below 3, so no upper clamp.
  always_comb begin
    underflow  = 1'b0;
    pending_d  = 32'd0;
    inflight_d = 7'd0;
    cnt_d[0]   = 2'd0;
    for (int r = 1; r < 32; r++) begin
      logic [2:0] sum;
      sum = {1'b0, cnt_q[r]}
          + {2'b00, issue && ID_RegWrite && (ID_rd == 5'(r))};
      if (sum < {1'b0, dec[r]}) begin
        cnt_d[r]  = 2'd0;
        underflow = 1'b1;
      end else begin
        cnt_d[r] = 2'(sum - {1'b0, dec[r]});
      end
    end
    // Flush wins over everything, including this cycle's underflow.
    if (Flush_all) begin
      underflow = 1'b0;
      for (int r = 1; r < 32; r++) begin
        cnt_d[r] = 2'd0;
      end
    end
    for (int r = 1; r < 32; r++) begin
      pending_d[r] = (cnt_d[r] != 2'd0);
      inflight_d   = inflight_d + 7'(cnt_d[r]);
    end
    error_d = error_q || underflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= 2'd0;
      end
      pending_q  <= 32'd0;
      inflight_q <= 7'd0;
      error_q    <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

  assign Pending  = pending_q;
  assign InFlight = inflight_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        ID_valid;
  logic [4:0]  ID_rs1, ID_rs2;
  logic        ID_use_rs1, ID_use_rs2;
  logic [4:0]  ID_rd;
  logic        ID_RegWrite;
  logic [4:0]  WB_rd;
  logic        WB_RegWrite;
  logic [4:0]  KILL_rd;
  logic        KILL_valid;
  logic        Flush_all;
  logic        Stall;
  logic [31:0] Pending;
  logic [6:0]  InFlight;
  logic        Error;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .ID_valid    (ID_valid),
    .ID_rs1      (ID_rs1),
    .ID_rs2      (ID_rs2),
    .ID_use_rs1  (ID_use_rs1),
    .ID_use_rs2  (ID_use_rs2),
    .ID_rd       (ID_rd),
    .ID_RegWrite (ID_RegWrite),
    .WB_rd       (WB_rd),
    .WB_RegWrite (WB_RegWrite),
    .KILL_rd     (KILL_rd),
    .KILL_valid  (KILL_valid),
    .Flush_all   (Flush_all),
    .Stall       (Stall),
    .Pending     (Pending),
    .InFlight    (InFlight),
    .Error       (Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_valid = 0; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    ID_rd = 0; ID_RegWrite = 0; WB_rd = 0; WB_RegWrite = 0;
    KILL_rd = 0; KILL_valid = 0; Flush_all = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    ID_valid = 1; ID_RegWrite = 1; ID_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    chk("reset_pending", Pending, 32'd0);
    chk("reset_inflight", {25'd0, InFlight}, 32'd0);
    chk("reset_error", {31'd0, Error}, 32'd0);
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    tick();
    reset = 0;
    tick();

    // RAW on x5, released by same-cycle writeback
    issue_wr(5'd5);
    #1 chk("x5_issue_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("x5_pending", Pending, 32'h0000_0020);
    chk("x5_inflight", {25'd0, InFlight}, 32'd1);
    idle(); ID_valid = 1; ID_rs1 = 5'd5; ID_use_rs1 = 1;
    #1 chk("x5_raw_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("x5_held_pending", Pending, 32'h0000_0020);
    WB_rd = 5'd5; WB_RegWrite = 1;
    #1 chk("x5_wb_bypass_stall", {31'd0, Stall}, 32'd0);
    tick();
    idle();
    chk("x5_cleared_pending", Pending, 32'd0);
    chk("x5_cleared_inflight", {25'd0, InFlight}, 32'd0);

    // Saturation on x7
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd7);
      tick();
    end
    chk("x7_inflight3", {25'd0, InFlight}, 32'd3);
    chk("x7_pending", Pending, 32'h0000_0080);
    issue_wr(5'd7);
    #1 chk("x7_dest_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("x7_still3", {25'd0, InFlight}, 32'd3);
    WB_rd = 5'd7; WB_RegWrite = 1;
    #1 chk("x7_wb_nostall", {31'd0, Stall}, 32'd0);
    tick();
    chk("x7_net_stays3", {25'd0, InFlight}, 32'd3);
    idle();
    for (int i = 0; i < 3; i++) begin
      WB_rd = 5'd7; WB_RegWrite = 1;
      tick();
    end
    idle();
    chk("x7_drained", {25'd0, InFlight}, 32'd0);
    chk("x7_no_error", {31'd0, Error}, 32'd0);

    // x0 is ignored everywhere
    issue_wr(5'd0);
    ID_rs1 = 5'd0; ID_use_rs1 = 1; ID_rs2 = 5'd0; ID_use_rs2 = 1;
    #1 chk("x0_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("x0_inflight", {25'd0, InFlight}, 32'd0);
    idle(); WB_rd = 5'd0; WB_RegWrite = 1; KILL_rd = 5'd0; KILL_valid = 1;
    tick();
    idle();
    chk("x0_no_error", {31'd0, Error}, 32'd0);

    // Inc and dec on the same register net out
    issue_wr(5'd3);
    tick();
    issue_wr(5'd3); WB_rd = 5'd3; WB_RegWrite = 1;
    #1 chk("x3_net_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("x3_net_inflight", {25'd0, InFlight}, 32'd1);
    chk("x3_net_pending", Pending, 32'h0000_0008);
    idle(); KILL_rd = 5'd3; KILL_valid = 1;
    tick();
    idle();
    chk("x3_killed", {25'd0, InFlight}, 32'd0);

    // WB + KILL on the same register decrement by 2
    issue_wr(5'd20); tick();
    issue_wr(5'd20); tick();
    chk("x20_two", {25'd0, InFlight}, 32'd2);
    idle(); WB_rd = 5'd20; WB_RegWrite = 1; KILL_rd = 5'd20; KILL_valid = 1;
    tick();
    idle();
    chk("x20_dec2", {25'd0, InFlight}, 32'd0);
    chk("x20_no_error", {31'd0, Error}, 32'd0);

    // Flush with writes pending on x1..x4; underflowing kill is masked
    for (int r = 1; r <= 4; r++) begin
      issue_wr(5'(r));
      tick();
    end
    chk("flush_pre_pending", Pending, 32'h0000_001E);
    chk("flush_pre_inflight", {25'd0, InFlight}, 32'd4);
    idle(); Flush_all = 1; WB_rd = 5'd1; WB_RegWrite = 1;
    KILL_rd = 5'd5; KILL_valid = 1;
    ID_valid = 1; ID_rs1 = 5'd2; ID_use_rs1 = 1;
    #1 chk("flush_cycle_stall", {31'd0, Stall}, 32'd1);
    tick();
    idle();
    chk("flush_pending", Pending, 32'd0);
    chk("flush_inflight", {25'd0, InFlight}, 32'd0);
    chk("flush_error", {31'd0, Error}, 32'd0);

    // Asynchronous reset mid-operation
    for (int r = 10; r <= 14; r++) begin
      issue_wr(5'(r));
      tick();
    end
    idle();
    chk("arst_pre_inflight", {25'd0, InFlight}, 32'd5);
    #2 reset = 1;
    #1;
    chk("arst_pending", Pending, 32'd0);
    chk("arst_inflight", {25'd0, InFlight}, 32'd0);
    #1 reset = 0;
    ID_valid = 1; ID_rs1 = 5'd10; ID_use_rs1 = 1;
    #1 chk("arst_read_stall", {31'd0, Stall}, 32'd0);
    tick();
    issue_wr(5'd10);
    tick();
    chk("arst_from_empty", {25'd0, InFlight}, 32'd1);
    idle(); WB_rd = 5'd10; WB_RegWrite = 1;
    tick();
    idle();
    chk("arst_drained", {25'd0, InFlight}, 32'd0);

    // Underflow sets sticky Error
    issue_wr(5'd9);
    tick();
    idle(); WB_rd = 5'd9; WB_RegWrite = 1; KILL_rd = 5'd9; KILL_valid = 1;
    tick();
    idle();
    chk("x9_pending", Pending, 32'd0);
    chk("x9_inflight", {25'd0, InFlight}, 32'd0);
    chk("x9_error", {31'd0, Error}, 32'd1);
    Flush_all = 1;
    tick();
    idle();
    tick();
    chk("x9_error_sticky", {31'd0, Error}, 32'd1);
    reset = 1;
    #1 chk("x9_error_reset", {31'd0, Error}, 32'd0);
    tick();
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 ID_valid  in  1  instruction present in decode.
REQ-005 ID_rs1, ID_rs2  in  5 each  decode source registers.
REQ-006 ID_use_rs1, ID_use_rs2  in  1 each  source actually read by the instruction.
REQ-007 ID_rd  in  5  decode destination register.
REQ-008 ID_RegWrite  in  1  decode instruction writes ID_rd.
REQ-009 WB_rd  in  5  retiring destination register.
REQ-010 WB_RegWrite  in  1  retiring write valid.
REQ-011 KILL_rd  in  5  destination of a squashed in-flight instruction.
REQ-012 KILL_valid  in  1  one squashed writer this cycle.
REQ-013 Flush_all  in  1  discard all outstanding writes.
REQ-014 Stall  out  1  combinational; decode must hold.
REQ-015 Pending  out  32  registered; bit r = cnt[r] != 0.
REQ-016 InFlight  out  7  registered; sum of all cnt[r].
REQ-017 Error  out  1  registered, sticky; counter underflow detected.

Function
REQ-018 SHALL keep a 2-bit saturating-at-3 count cnt[r] of outstanding writes per register r=1..31; cnt[0] SHALL be constant 0.
REQ-019 dec[r] SHALL be (WB_RegWrite && WB_rd==r) + (KILL_valid && KILL_rd==r), range 0..2.
REQ-020 eff[r] SHALL be cnt[r] minus dec[r], floored at 0 (same-cycle writeback bypass).
REQ-021 Source hazard SHALL be ID_use_rsN && ID_rsN!=0 && eff[ID_rsN]!=0, for N=1,2.
REQ-022 Dest hazard SHALL be ID_RegWrite && ID_rd!=0 && eff[ID_rd]==3.
REQ-023 Stall SHALL be ID_valid && (either source hazard || dest hazard); Stall SHALL be 0 when ID_valid=0.
REQ-024 issue SHALL be ID_valid && !Stall; inc[r] = issue && ID_RegWrite && ID_rd==r && r!=0.
REQ-025 Next cnt[r] SHALL be cnt[r] + inc[r] - dec[r], computed in 3 bits.
REQ-026 A negative result SHALL store 0 and set Error.
REQ-027 A result above 3 is unreachable by REQ-022; no clamp beyond 3 is needed.
REQ-028 Simultaneous inc and dec to the same r SHALL net out in one cycle; for example, cnt=1 with inc and WB dec gives 1.
REQ-029 WB and KILL to the same r in the same cycle SHALL decrement by 2.
REQ-030 Any write to register 0 (issue, WB or KILL) SHALL be ignored and SHALL never set Error.
REQ-031 Flush_all SHALL zero every cnt at the next edge; it overrides inc and dec, and that cycle's decrements SHALL NOT set Error.
REQ-032 Stall in the Flush_all cycle SHALL still be computed from the current eff values.
REQ-033 Pending and InFlight SHALL reflect the registered cnt values (one-cycle latency after the causing edge).
REQ-034 Error SHALL clear only on reset.

Reset
REQ-035 On reset assertion, all cnt, Pending, InFlight and Error SHALL go to 0 asynchronously, without waiting for clk.
REQ-036 Stall SHALL be 0 during reset unless a source register is pending; since all counts are zero, Stall is effectively 0.
REQ-037 Reset asserted mid-operation SHALL discard all outstanding counts; the first edge after deassertion SHALL behave as from empty.

Verification
REQ-038 Issue write x5, then next cycle decode reads rs1=x5 -> Stall=1, Pending[5]=1, InFlight=1; in the cycle with WB_rd=5 and WB_RegWrite=1 -> Stall=0, then Pending[5]=0.
REQ-039 Issue three writes to x7 with no WB, then a fourth -> fourth cycle Stall=1 (dest hazard), cnt[7]=3, InFlight=3; same cycle plus WB x7 -> Stall=0 and cnt stays 3.
REQ-040 cnt[9]=1, WB_rd=9 and KILL_rd=9 in the same cycle -> cnt[9]=0 and Error=1; Error remains 1 until reset.
REQ-041 Issue writes to x0 and reads of x0 with use=1 -> Stall=0, InFlight=0, Error=0.
REQ-042 Writes pending on x1..x4, then Flush_all=1 with WB x1 -> next cycle Pending=0, InFlight=0, Error=0.
REQ-043 Reset pulsed between clock edges with InFlight=5 -> outputs 0 before the next edge; a read of the previously pending register after release -> Stall=0.
